// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage between the 32-bit ALU result bus and the
// 16-bit register-file write port. A narrow result takes one write beat, a
// wide result takes two (low half to dest, high half to dest+1, wrapping).
// Z/N/O flags are captured when a result is accepted.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0]   in_dest,
    input  logic                in_wide,
    input  logic                rf_ready,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                flag_z,
    output logic                flag_n,
    output logic                flag_o,
    output logic                flag_upd,
    output logic [CNT_W-1:0]    wb_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_wide;
    logic [DATA_W-1:0]   r_hi;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_flag_z;
    logic                r_flag_n;
    logic                r_flag_o;
    logic                r_flag_upd;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_beat_done;
    logic                w_lo_to_hi;

    // Handshake and beat-completion qualifiers, all derived from registered state.
    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_beat_done = (r_state != IDLE) && rf_ready;
    assign w_lo_to_hi  = (r_state == WR_LO) && rf_ready && r_wide;

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, regardless of block order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // w_next, so no latch is inferred.
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = WR_LO;
            WR_LO:   if (rf_ready) w_next = r_wide ? WR_HI : IDLE;
            WR_HI:   if (rf_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch the result on accept, advance to the high half after
    // the low beat, capture flags and count completed beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wide     <= 1'b0;
            r_hi       <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
            r_flag_o   <= 1'b0;
            r_flag_upd <= 1'b0;
            r_count    <= '0;
        end else begin
            r_flag_upd <= w_accept;
            if (w_accept) begin
                r_wide   <= in_wide;
                r_hi     <= in_result[2*DATA_W-1:DATA_W];
                r_waddr  <= in_dest;
                r_wdata  <= in_result[DATA_W-1:0];
                r_flag_z <= in_wide ? (in_result == '0)
                                    : (in_result[DATA_W-1:0] == '0);
                r_flag_n <= in_wide ? in_result[2*DATA_W-1]
                                    : in_result[DATA_W-1];
                r_flag_o <= |in_result[2*DATA_W-1:DATA_W];
            end
            if (w_lo_to_hi) begin
                r_waddr <= r_waddr + ADDR_W'(1);
                r_wdata <= r_hi;
            end
            if (w_beat_done) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign in_ready = (r_state == IDLE);
    assign rf_we    = (r_state != IDLE);
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign flag_z   = r_flag_z;
    assign flag_n   = r_flag_n;
    assign flag_o   = r_flag_o;
    assign flag_upd = r_flag_upd;
    assign wb_count = r_count;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed vectors with hand-computed expectations for the
// writeback stage: reset, narrow/wide writes, address wrap, stall, flags,
// reset mid-write and back-to-back throughput.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_dest;
    logic        in_wide;
    logic        rf_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_z;
    logic        flag_n;
    logic        flag_o;
    logic        flag_upd;
    logic [15:0] wb_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_dest   (in_dest),
        .in_wide   (in_wide),
        .rf_ready  (rf_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_o    (flag_o),
        .flag_upd  (flag_upd),
        .wb_count  (wb_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [2:0] addr,
                              input logic [15:0] data);
        check({tag, ".we"},   {31'd0, rf_we},    {31'd0, we});
        check({tag, ".addr"}, {29'd0, rf_waddr}, {29'd0, addr});
        check({tag, ".data"}, {16'd0, rf_wdata}, {16'd0, data});
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n,
                               input logic o, input logic upd);
        check({tag, ".z"},   {31'd0, flag_z},   {31'd0, z});
        check({tag, ".n"},   {31'd0, flag_n},   {31'd0, n});
        check({tag, ".o"},   {31'd0, flag_o},   {31'd0, o});
        check({tag, ".upd"}, {31'd0, flag_upd}, {31'd0, upd});
    endtask

    task automatic present(input logic [31:0] res, input logic [2:0] dest, input logic wide);
        in_valid  = 1'b1;
        in_result = res;
        in_dest   = dest;
        in_wide   = wide;
    endtask

    initial begin
        int accepts;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0;
        in_wide = 1'b0; rf_ready = 1'b1;

        // 1: reset for two cycles
        tick(); tick();
        rst = 1'b0;
        check_port("rst", 1'b0, 3'd0, 16'h0000);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst.count", {16'd0, wb_count}, 32'd0);
        check("rst.ready", {31'd0, in_ready}, 32'd1);

        // 2: narrow write
        present(32'h0000_00F0, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        check_port("nar", 1'b1, 3'd3, 16'h00F0);
        check_flags("nar", 1'b0, 1'b0, 1'b0, 1'b1);
        check("nar.ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_port("nar.done", 1'b0, 3'd3, 16'h00F0);
        check("nar.count", {16'd0, wb_count}, 32'd1);
        check("nar.upd_off", {31'd0, flag_upd}, 32'd0);
        check("nar.ready2", {31'd0, in_ready}, 32'd1);

        // 3: wide write with address wrap 7 -> 0
        present(32'h8001_0000, 3'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        check_port("wide.b1", 1'b1, 3'd7, 16'h0000);
        check_flags("wide", 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check_port("wide.b2", 1'b1, 3'd0, 16'h8001);
        check("wide.count_b1", {16'd0, wb_count}, 32'd2);
        check("wide.upd_off", {31'd0, flag_upd}, 32'd0);
        tick();
        check("wide.we_off", {31'd0, rf_we}, 32'd0);
        check("wide.count", {16'd0, wb_count}, 32'd3);

        // 4: stall in WR_LO for four cycles; in_valid pulses ignored
        rf_ready = 1'b0;
        present(32'h0000_1234, 3'd2, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid  = i[0];
            in_result = 32'hDEAD_BEEF;
            in_dest   = 3'd6;
            in_wide   = 1'b1;
            tick();
            check_port($sformatf("stall%0d", i), 1'b1, 3'd2, 16'h1234);
            check($sformatf("stall%0d.ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall%0d.count", i), {16'd0, wb_count}, 32'd3);
        end
        in_valid = 1'b0;
        check_flags("stall", 1'b0, 1'b0, 1'b0, 1'b0);
        rf_ready = 1'b1;
        tick();
        check("stall.we_off", {31'd0, rf_we}, 32'd0);
        check("stall.count", {16'd0, wb_count}, 32'd4);

        // 5: zero flag, narrow vs wide on the same result
        present(32'h0001_0000, 3'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_flags("zn", 1'b1, 1'b0, 1'b1, 1'b1);
        check_port("zn", 1'b1, 3'd1, 16'h0000);
        tick();
        present(32'h0001_0000, 3'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        check_flags("zw", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_port("zw.b2", 1'b1, 3'd2, 16'h0001);
        tick();
        check("zw.count", {16'd0, wb_count}, 32'd7);

        // 6a: reset while in WR_HI abandons the high beat
        present(32'hFFFF_1111, 3'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check_port("rmid.hi", 1'b1, 3'd6, 16'hFFFF);
        check("rmid.count_pre", {16'd0, wb_count}, 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_port("rmid", 1'b0, 3'd0, 16'h0000);
        check_flags("rmid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rmid.count", {16'd0, wb_count}, 32'd0);
        check("rmid.ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("rmid.we_stays", {31'd0, rf_we}, 32'd0);

        // 6b: back-to-back narrow accepts at max rate
        accepts = 0;
        present(32'h0000_0042, 3'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        check("b2b.accepts", accepts, 32'd4);
        check("b2b.count", {16'd0, wb_count}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
